// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   muldiv_op_t    : request encoding presented on the op port
//   muldiv_state_t : control FSM states
//   MULDIV_ITERS   : default operand width, which is also the iteration count
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIN  = 2'b11
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// -----------------------------------------------------------------------------
// cond_negate
// Conditional two's-complement negation.
//   i_neg : negate when high, pass through when low
//   i_val : input value
//   o_val : i_neg ? -i_val : i_val (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide engine owning the HI/LO register pair.
// A request accepted in IDLE runs WIDTH shift-add (MUL) or restoring
// shift-subtract (DIV) steps on operand magnitudes; the sign-corrected result
// lands in HI/LO on the last step edge and done pulses in the following FIN
// cycle. A zero divisor short-circuits to FIN after a single DIV cycle.
//   clk, reset       : clock, synchronous active-high reset
//   start, op, a, b  : request (sampled only in IDLE)
//   hi_we, lo_we     : mthi/mtlo write enables with wdata (IDLE only, start wins)
//   busy, done       : busy outside IDLE, done one-cycle pulse in FIN
//   div_zero         : sticky zero-divisor flag, cleared by the next start
//   hi, lo           : architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_next;

    // MUL: {partial product high, multiplier shifting out / product low}
    // DIV: {remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;        // multiplicand (MUL) or divisor (DIV) magnitude
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder (sign of dividend)
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    muldiv_op_t         w_op;
    logic               w_signed;
    logic               w_is_div;
    logic               w_last;
    logic               w_b_zero;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_div_next;

    logic [WIDTH-1:0]   w_n0_in, w_n0_out, w_n1_in, w_n1_out;
    logic               w_n0_neg, w_n1_neg;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_op     = muldiv_op_t'(op);
    assign w_signed = op_is_signed(w_op);
    assign w_is_div = op_is_div(w_op);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_b_zero = (r_b == '0);

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator (with carry) right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: shifted remainder is WIDTH+1 bits wide. When it is
    // >= divisor the true difference is < 2^WIDTH, so a WIDTH-bit subtract
    // is exact.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
    assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    // The two WIDTH-bit negators take operand magnitudes in IDLE and sign-fix
    // remainder/quotient otherwise. With a zero divisor the untouched dividend
    // magnitude is routed through the remainder path, which restores a.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_n0_in  = w_div_next[2*WIDTH-1:WIDTH];
        w_n0_neg = r_neg_hi;
        w_n1_in  = w_div_next[WIDTH-1:0];
        w_n1_neg = r_neg_lo;
        if (r_state == IDLE) begin
            w_n0_in  = a;
            w_n0_neg = w_signed & a[WIDTH-1];
            w_n1_in  = b;
            w_n1_neg = w_signed & b[WIDTH-1];
        end else if (w_b_zero) begin
            w_n0_in  = r_acc[WIDTH-1:0];
        end
    end

    cond_negate #(.WIDTH(WIDTH)) u_neg_hi (
        .i_neg (w_n0_neg),
        .i_val (w_n0_in),
        .o_val (w_n0_out)
    );

    cond_negate #(.WIDTH(WIDTH)) u_neg_lo (
        .i_neg (w_n1_neg),
        .i_val (w_n1_in),
        .o_val (w_n1_out)
    );

    cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_neg (r_neg_lo),
        .i_val (w_mul_next),
        .o_val (w_prod_fix)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = (r_state == FIN);
        case (r_state)
            IDLE:    if (start) w_state_next = w_is_div ? DIV : MUL;
            MUL:     if (w_last) w_state_next = FIN;
            DIV:     if (w_b_zero || w_last) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_b        <= '0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Multiplier sits in the low half so its bits shift
                        // out as the product shifts in; the dividend likewise.
                        r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_n0_out : w_n1_out)};
                        r_b        <= w_is_div ? w_n1_out : w_n0_out;
                        r_neg_lo   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_hi   <= w_signed & a[WIDTH-1];
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                DIV: begin
                    if (w_b_zero) begin
                        r_hi       <= w_n0_out;
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_hi <= w_n0_out;
                            r_lo <= w_n1_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: each issued request pushes its expected
// HI/LO/div_zero and done cycle; a negedge monitor pops on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_txn = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("txn%0d_hi", n_txn), 64'(hi), 64'(mon_e.hi));
                check($sformatf("txn%0d_lo", n_txn), 64'(lo), 64'(mon_e.lo));
                check($sformatf("txn%0d_div_zero", n_txn), 64'(div_zero), 64'(mon_e.dz));
                check($sformatf("txn%0d_done_cycle", n_txn), 64'(cyc), 64'(mon_e.cyc));
                check($sformatf("txn%0d_busy_at_done", n_txn), 64'(busy), 64'd1);
                n_txn++;
            end
        end
    end

    // Called at a negedge; drives start for one edge and returns at the
    // negedge after it. lat counts negedges from issue to the done cycle.
    task automatic issue(input muldiv_op_t op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic push, input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input logic e_dz, input int unsigned lat);
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        if (push) sb.push_back('{hi: e_hi, lo: e_lo, dz: e_dz, cyc: cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    task automatic run(input string name, input muldiv_op_t op_v, input logic [31:0] a_v,
                       input logic [31:0] b_v, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dz, input int unsigned lat);
        issue(op_v, a_v, b_v, 1'b1, e_hi, e_lo, e_dz, lat);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic products and quotients.
        issue(OP_MULTU, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, 1'b0, 33);
        check("multu_busy_after_start", 64'(busy), 64'd1);
        wait_done("multu_7x6");
        check("idle_after_fin", 64'(busy), 64'd0);
        run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        run("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        run("mult_minxmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33);
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        run("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run("div_7_neg2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
        run("div_min_neg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);

        // Zero divisor: early finish, sticky flag, cleared by the next start.
        run("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2);
        run("div_neg5_0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2);
        check("div_zero_sticky", 64'(div_zero), 64'd1);
        issue(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'h0, 32'd12, 1'b0, 33);
        check("div_zero_cleared", 64'(div_zero), 64'd0);
        wait_done("multu_3x4");

        // mthi/mtlo in IDLE.
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'd12);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", 64'(hi), 64'hABCD);
        check("mthilo_lo", 64'(lo), 64'hABCD);

        // start with a simultaneous write: start wins, write is dropped.
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        issue(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6, 1'b0, 33);
        hi_we = 1'b0;
        check("start_wins_hi", 64'(hi), 64'hABCD);
        repeat (3) @(negedge clk);
        // Writes and a new start during MUL are both ignored.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_write_hi", 64'(hi), 64'hABCD);
        check("busy_write_lo", 64'(lo), 64'hABCD);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 64'(busy), 64'd1);
        wait_done("multu_2x3");
        repeat (40) @(negedge clk);

        // Reset mid-divide aborts with no done pulse.
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run("multu_3x3", OP_MULTU, 32'd3, 32'd3, 32'h0, 32'd9, 1'b0, 33);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide engine that owns the architectural HI/LO register pair. It accepts mult/div requests from the datapath and computes them over 32 cycles with a start/busy/done handshake. Results are read back through the hi/lo outputs (mfhi/mflo), and hi/lo are written directly for mthi/mtlo. It replaces the single-edge HiLo update with a timed, interlockable unit that the control FSM stalls on.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
op  input  2  muldiv_op_t: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  input  WIDTH  multiplicand / dividend.
b  input  WIDTH  multiplier / divisor.
hi_we  input  1  mthi write enable; honoured only in IDLE.
lo_we  input  1  mtlo write enable; honoured only in IDLE.
wdata  input  WIDTH  data for hi_we/lo_we.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
div_zero  output  1  sticky flag for the last divide; set on b==0, cleared on the next accepted start.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0.
- Reset mid-operation aborts the operation. The next cycle is IDLE with hi=lo=0 and no done pulse.
- States: IDLE, MUL, DIV, FIN.
- IDLE to MUL/DIV: on start at edge E0, latch |a|, |b| (magnitudes if op is signed, raw otherwise), the result-sign bits and op, and clear the counter.
- MUL: one shift-add step per edge, 64-bit accumulator.
- DIV: one restoring shift-subtract step per edge, remainder/quotient pair.
- After the 32nd iteration (edge E32), go to FIN. On that edge, write hi/lo with the sign-corrected result.
- FIN: done=1 for exactly one cycle, then IDLE at E33. Total latency is start edge to done cycle = 33 cycles.
- Divide by b==0: skip the iterations and go DIV to FIN at E1. Set hi=a, lo={WIDTH{1}}, div_zero=1. done is high in the cycle after E1.
- Sign rules:
  - MULT: negate the 64-bit product if a[31]^b[31].
  - DIV: negate the quotient if a[31]^b[31]; the remainder takes the sign of a.
  - The most-negative DIV by -1 wraps: lo=0x80000000, hi=0.
- Handshake rules:
  - start while busy is ignored, with no queuing.
  - hi_we/lo_we while busy are dropped.
  - start and hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
  - hi_we and lo_we together: both registers are written.
- hi/lo are stable in every state except the FIN-entry edge and IDLE writes. Reads during busy return the previous result.
- Unsigned arithmetic is modulo 2^64 for products and exact for quotient/remainder.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum muldiv_op_t {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV}.
  - typedef enum muldiv_state_t {IDLE, MUL, DIV, FIN}.
  - localparam MULDIV_ITERS = 32.
- Sub-module cond_negate (WIDTH-parameterised conditional two's-complement) is used for operand magnitudes and result sign correction; it is instantiated three times.

Test Plan:
- MULTU a=7, b=6 -> busy for 33 cycles, done pulse in cycle 33, hi=0x00000000, lo=0x0000002A.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div_zero=0 in both cases.
- DIVU a=5, b=0 -> done in the cycle after E1, hi=5, lo=0xFFFFFFFF, div_zero=1. Next MULTU start clears div_zero.
- hi_we with wdata=0x1234 while IDLE -> hi=0x1234 next cycle. Same write during MUL -> ignored. start during MUL -> ignored, and the original result and timing are unchanged.
- Assert reset at iteration 10 of DIVU -> next cycle busy=0, done never pulses, hi=lo=0. A fresh MULTU 3*3 then completes with lo=9.
